pagerank_row_fetcher: RTL and testbench
=======================================

PAGERANK_ROW_FETCHER -- requirements
Module: pagerank_row_fetcher

Interface
REQ-001 Parameter n, default 8: 32-bit words fetched per command (one graph-matrix row); legal range 1..255.
REQ-002 Parameter D, default 4: response-buffer depth and maximum in-flight credit; power of two, 2..16.
REQ-003 clk  input  1  sole clock; one clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_val  input  1  command valid.
REQ-006 cmd_rdy  output  1  command ready; high only in IDLE.
REQ-007 cmd_addr  input  32  byte base address of row.
REQ-008 mem_req_msg  output  77  {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}.
REQ-009 mem_req_val / mem_req_rdy  output / input  1 / 1  memory request handshake.
REQ-010 mem_resp_msg  input  47  {type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}.
REQ-011 mem_resp_val / mem_resp_rdy  input / output  1 / 1  memory response handshake.
REQ-012 out_data  output  32  row word toward mapper inputs.
REQ-013 out_val / out_rdy / out_last  output / input / output  1 each  output stream; out_last marks word n-1.
REQ-014 err  output  1  sticky response-ordering error flag.

Function
REQ-015 Transfer occurs when val and rdy are both high in the same cycle, on every interface.
REQ-016 States: IDLE, FETCH, DRAIN; cmd accept in IDLE latches cmd_addr, clears req_cnt, out_cnt, err, goes to FETCH.
REQ-017 FETCH: mem_req_val high when req_cnt < n and (inflight + fifo_count) < D; first mem_req_val is the cycle after cmd accept.
REQ-018 Request k: type=0 (read), opaque=k[7:0], addr=base+4*k mod 2^32, len=0, data=0; req_cnt increments on each request transfer.
REQ-019 Request transfer with req_cnt = n-1 moves FETCH to DRAIN next cycle.
REQ-020 mem_resp_rdy constantly 1; in FETCH/DRAIN each response pushes data into D-entry FIFO and decrements inflight; credit rule guarantees no overflow.
REQ-021 Same-cycle request and response: inflight unchanged; same-cycle FIFO push and pop: count unchanged.
REQ-022 Response opaque compared with expected index (count of responses received this command); mismatch sets err, word still buffered.
REQ-023 Responses in IDLE are accepted and discarded; no FIFO write, err unchanged.
REQ-024 out_val = FIFO non-empty; out_data = FIFO head, combinational; word visible at earliest the cycle after its response.
REQ-025 out_last = out_val and out_cnt = n-1; out_cnt increments on each output transfer.
REQ-026 Output transfer with out_cnt = n-1 returns block to IDLE next cycle; cmd_rdy high that cycle.
REQ-027 out_data, out_val, mem_req_msg hold stable while val high and rdy low.
REQ-028 No new command accepted until all n words delivered; no pipelining across commands.

Reset
REQ-029 Reset: state IDLE, counters and inflight 0, FIFO empty, err 0.
REQ-030 Reset outputs: cmd_rdy=1, mem_req_val=0, mem_resp_rdy=1, out_val=0, out_last=0, out_data=0, mem_req_msg=0.
REQ-031 Reset mid-command aborts immediately; buffered words lost; late responses dropped per REQ-023.

Verification
REQ-032 cmd_addr=0x1000, zero-latency memory, out_rdy=1 -> reads 0x1000..0x101C opaque 0..7, 8 words in order, out_last on 8th only, cmd_rdy next cycle.
REQ-033 out_rdy=0 throughout -> exactly D=4 requests issued then mem_req_val=0; raising out_rdy resumes, all 8 delivered.
REQ-034 mem_req_rdy toggled 1/0, random response delay 0..5 -> requests held stable while stalled, data intact, no overflow.
REQ-035 Response opaque 3 delivered where 2 expected -> err=1 until next cmd accept; all 8 words still output.
REQ-036 Reset asserted after 3 outputs -> next cycle outputs at reset values; new cmd at 0x2000 fetches a clean row, err=0.
REQ-037 cmd_addr=0xFFFFFFF8, n=8 -> addresses wrap to 0x00000000..0x00000014.

Source files
------------

// File: rtl/pagerank_row_fetcher.sv
// pagerank_row_fetcher
// Fetches one graph-matrix row of n 32-bit words per command from memory and
// streams the words, in order, toward the mapper inputs.
//
// Ports
//   clk, reset            sole clock, synchronous active-high reset
//   cmd_val/cmd_rdy       command handshake, cmd_addr = byte base address of row
//   mem_req_*             read requests {type,opaque,addr,len,data} (77 bits)
//   mem_resp_*            read responses {type,opaque,test,len,data} (47 bits)
//   out_data/val/rdy/last row word stream, out_last marks word n-1
//   err                   sticky flag: a response arrived with an unexpected opaque
//
// state  | meaning
// IDLE   | waiting for a command, cmd_rdy high, stray responses dropped
// FETCH  | issuing reads while credit allows, buffering and streaming words
// DRAIN  | all reads issued, waiting for the remaining words to be delivered
module pagerank_row_fetcher #(
  parameter int unsigned n = 8,
  parameter int unsigned D = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_addr,
  output logic [76:0] mem_req_msg,
  output logic        mem_req_val,
  input  logic        mem_req_rdy,
  input  logic [46:0] mem_resp_msg,
  input  logic        mem_resp_val,
  output logic        mem_resp_rdy,
  output logic [31:0] out_data,
  output logic        out_val,
  input  logic        out_rdy,
  output logic        out_last,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int unsigned AW = $clog2(D);
  localparam int unsigned CW = AW + 1;
  localparam logic [7:0]    N_W   = 8'(n);
  localparam logic [7:0]    N_M1  = 8'(n - 1);
  localparam logic [CW-1:0] D_C   = CW'(D);

  logic [1:0]    state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [7:0]    req_cnt_q, req_cnt_d;
  logic [7:0]    out_cnt_q, out_cnt_d;
  logic [7:0]    rsp_cnt_q, rsp_cnt_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [D];

  logic          active, credit_ok, req_fire, rsp_take, push, pop, rsp_dec;
  logic [7:0]    rsp_opaque;
  logic [31:0]   rsp_data, req_addr;
  logic          unused_rsp_fields;

  assign rsp_opaque        = mem_resp_msg[43:36];
  assign rsp_data          = mem_resp_msg[31:0];
  assign unused_rsp_fields = ^{mem_resp_msg[46:44], mem_resp_msg[35:32]};

  assign active       = (state_q != S_IDLE);
  assign cmd_rdy      = (state_q == S_IDLE);
  assign mem_resp_rdy = 1'b1;
  assign err          = err_q;

  // Buffered plus outstanding words may never exceed the buffer depth, so every
  // response always finds a free FIFO slot.
  assign credit_ok   = ({1'b0, inflight_q} + {1'b0, count_q}) < {1'b0, D_C};
  assign mem_req_val = (state_q == S_FETCH) && (req_cnt_q < N_W) && credit_ok;
  assign req_addr    = base_q + {22'd0, req_cnt_q, 2'b00};
  assign mem_req_msg = mem_req_val ? {3'd0, req_cnt_q, req_addr, 2'd0, 32'd0} : 77'd0;
  assign req_fire    = mem_req_val && mem_req_rdy;

  assign out_val  = (count_q != '0);
  assign out_data = out_val ? mem_q[rptr_q] : 32'd0;
  assign out_last = out_val && (out_cnt_q == N_M1);
  assign pop      = out_val && out_rdy;

  assign rsp_take = mem_resp_val && active;
  assign push     = rsp_take && ((count_q != D_C) || pop);
  assign rsp_dec  = rsp_take && (inflight_q != '0);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    req_cnt_d  = req_cnt_q;
    out_cnt_d  = out_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q;

    if (req_fire)  req_cnt_d = req_cnt_q + 8'd1;
    if (pop)       out_cnt_d = out_cnt_q + 8'd1;
    if (push)      wptr_d    = wptr_q + AW'(1);
    if (pop)       rptr_d    = rptr_q + AW'(1);
    if (rsp_take) begin
      rsp_cnt_d = rsp_cnt_q + 8'd1;
      if (rsp_opaque != rsp_cnt_q) err_d = 1'b1;
    end

    case ({req_fire, rsp_dec})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (cmd_val) begin
          state_d    = S_FETCH;
          base_d     = cmd_addr;
          req_cnt_d  = 8'd0;
          out_cnt_d  = 8'd0;
          rsp_cnt_d  = 8'd0;
          inflight_d = '0;
          count_d    = '0;
          wptr_d     = '0;
          rptr_d     = '0;
          err_d      = 1'b0;
        end
      end
      S_FETCH: begin
        if (req_fire && (req_cnt_q == N_M1)) state_d = S_DRAIN;
        if (pop && (out_cnt_q == N_M1))      state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (pop && (out_cnt_q == N_M1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= 32'd0;
      req_cnt_q  <= 8'd0;
      out_cnt_q  <= 8'd0;
      rsp_cnt_q  <= 8'd0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      req_cnt_q  <= req_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: out_data is gated by out_val.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rsp_data;
  end

endmodule

// File: tb/tb_pagerank_row_fetcher.sv
module tb_pagerank_row_fetcher;
  localparam int N   = 8;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [31:0] cmd_addr;
  logic [76:0] mem_req_msg;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [46:0] mem_resp_msg;
  logic        mem_resp_val;
  logic        mem_resp_rdy;
  logic [31:0] out_data;
  logic        out_val;
  logic        out_rdy;
  logic        out_last;
  logic        err;

  always #5 clk = ~clk;

  pagerank_row_fetcher #(.n(N), .D(DEP)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr),
    .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy), .out_last(out_last),
    .err(err)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] data;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] base;
    int          out_mode;   // 0 always ready, 1 stalled until release, 2 random
    int          stall;      // cycles after accept at which the stall check runs
    int          req_toggle;
    int          max_dly;
    int          corrupt_idx;
    logic [31:0] exp_last_addr;
    logic        exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  pend_t pq[$];
  int    cyc = 0;
  int    last_due = 0;
  int    out_mode = 0, release_cyc = 0, stall_chk = 0, req_toggle = 0, max_dly = 0;
  int    corrupt_idx = -1;
  int    reqs = 0, outs = 0, accept_cyc = -100;
  bit    busy = 1'b0, cmd_pending = 1'b0, rst_req = 1'b0;
  logic [31:0] cur_base = 32'd0, pend_base = 32'd0, last_req_addr = 32'd0;
  logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
  logic [76:0] prev_msg = '0;
  logic [31:0] prev_od = '0;

  task automatic check(input string name, input logic [76:0] act, input logic [76:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  task automatic step();
    logic [31:0] ea;
    int          d;
    @(negedge clk);
    cyc++;
    reset       = rst_req;
    cmd_val     = cmd_pending;
    cmd_addr    = cmd_pending ? pend_base : 32'd0;
    mem_req_rdy = (req_toggle != 0) ? ((cyc % 2) == 0) : 1'b1;
    case (out_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = (cyc >= release_cyc);
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      mem_resp_val = 1'b1;
      mem_resp_msg = {3'd0, pq[0].op, 2'd0, 2'd0, pq[0].data};
      void'(pq.pop_front());
    end else begin
      mem_resp_val = 1'b0;
      mem_resp_msg = '0;
    end
    #1;
    if (reset) begin
      prev_rv = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (mem_resp_val) check("resp_rdy", 77'(mem_resp_rdy), 77'd1);
      if (prev_rv && !prev_rr) begin
        check("req_hold_val", 77'(mem_req_val), 77'd1);
        check("req_hold_msg", mem_req_msg, prev_msg);
      end
      if (prev_ov && !prev_or) begin
        check("out_hold_val", 77'(out_val), 77'd1);
        check("out_hold_data", 77'(out_data), 77'(prev_od));
      end
      if (busy) check("cmd_rdy_busy", 77'(cmd_rdy), 77'd0);
      if (cmd_val && cmd_rdy) begin
        cur_base    = pend_base;
        cmd_pending = 1'b0;
        reqs        = 0;
        outs        = 0;
        accept_cyc  = cyc;
        release_cyc = cyc + stall_chk + 1;
        busy        = 1'b1;
      end else if (cyc == accept_cyc + 1) begin
        check("first_req_val", 77'(mem_req_val), 77'd1);
        check("err_cleared", 77'(err), 77'd0);
      end
      if (mem_req_val && mem_req_rdy) begin
        ea = cur_base + 32'(reqs) * 32'd4;
        check("req_msg", mem_req_msg, {3'd0, 8'(reqs), ea, 2'd0, 32'd0});
        d = (max_dly > 0) ? int'($urandom_range(0, max_dly)) : 0;
        if (cyc + 1 + d > last_due) last_due = cyc + 1 + d;
        pq.push_back('{op: (reqs == corrupt_idx) ? 8'(reqs + 1) : 8'(reqs),
                       data: mem_data(ea), due: last_due});
        last_req_addr = ea;
        reqs++;
      end
      if (out_val && out_rdy) begin
        check("out_data", 77'(out_data), 77'(mem_data(cur_base + 32'(outs) * 32'd4)));
        check("out_last", 77'(out_last), 77'(outs == N - 1));
        outs++;
        if (outs == N) busy = 1'b0;
      end
      if (busy) check("credit", 77'((reqs - outs) <= DEP), 77'd1);
      prev_rv  = mem_req_val;
      prev_rr  = mem_req_rdy;
      prev_msg = mem_req_msg;
      prev_ov  = out_val;
      prev_or  = out_rdy;
      prev_od  = out_data;
    end
  endtask

  task automatic start_cmd(input logic [31:0] base);
    int guard;
    pend_base   = base;
    cmd_pending = 1'b1;
    guard = 0;
    while (cmd_pending && guard < 50) begin
      step();
      guard++;
    end
    if (cmd_pending) begin
      check("cmd_accept_timeout", 77'd0, 77'd1);
      cmd_pending = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int guard;
    out_mode    = v.out_mode;
    stall_chk   = v.stall;
    req_toggle  = v.req_toggle;
    max_dly     = v.max_dly;
    corrupt_idx = v.corrupt_idx;
    release_cyc = 1 << 30;
    start_cmd(v.base);
    guard = 0;
    while (outs < N && guard < 400) begin
      step();
      guard++;
      if (v.stall > 0 && cyc == accept_cyc + v.stall) begin
        check("stall_req_count", 77'(reqs), 77'(DEP));
        check("stall_req_val", 77'(mem_req_val), 77'd0);
      end
    end
    if (outs < N) check("row_timeout", 77'(outs), 77'(N));
    step();
    check("cmd_rdy_after", 77'(cmd_rdy), 77'd1);
    check("req_total", 77'(reqs), 77'(N));
    check("last_addr", 77'(last_req_addr), 77'(v.exp_last_addr));
    check("err_end", 77'(err), 77'(v.exp_err));
    if (v.exp_err) begin
      step();
      step();
      check("err_sticky", 77'(err), 77'd1);
    end
    corrupt_idx = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, 77'(cmd_rdy), 77'd1);
    check({tag, "_req_val"}, 77'(mem_req_val), 77'd0);
    check({tag, "_resp_rdy"}, 77'(mem_resp_rdy), 77'd1);
    check({tag, "_out_val"}, 77'(out_val), 77'd0);
    check({tag, "_out_last"}, 77'(out_last), 77'd0);
    check({tag, "_out_data"}, 77'(out_data), 77'd0);
    check({tag, "_req_msg"}, mem_req_msg, 77'd0);
    check({tag, "_err"}, 77'(err), 77'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h0000_1000, 0, 0,  0, 0, -1, 32'h0000_101C, 1'b0};
    vecs[1] = '{32'h0000_1000, 1, 40, 0, 0, -1, 32'h0000_101C, 1'b0};
    vecs[2] = '{32'h0000_3000, 2, 0,  1, 5, -1, 32'h0000_301C, 1'b0};
    vecs[3] = '{32'h0000_4000, 0, 0,  0, 0,  2, 32'h0000_401C, 1'b1};
    vecs[4] = '{32'hFFFF_FFF8, 0, 0,  0, 0, -1, 32'h0000_0014, 1'b0};

    reset = 1'b1; cmd_val = 1'b0; cmd_addr = '0; mem_req_rdy = 1'b1;
    mem_resp_val = 1'b0; mem_resp_msg = '0; out_rdy = 1'b1;

    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    step();
    check_reset_outputs("init");

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset after the third delivered word aborts the row.
    out_mode = 0; stall_chk = 0; req_toggle = 0; max_dly = 2; corrupt_idx = -1;
    start_cmd(32'h0000_5000);
    for (int g = 0; g < 100 && outs < 3; g++) step();
    check("pre_reset_outs", 77'(outs), 77'd3);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    busy = 1'b0;
    step();
    check_reset_outputs("midrst");
    for (int k = 0; k < 8; k++) begin
      step();
      check("late_resp_out_val", 77'(out_val), 77'd0);
      check("late_resp_err", 77'(err), 77'd0);
    end
    check("late_resp_flushed", 77'(pq.size()), 77'd0);
    max_dly = 0;
    run_vec('{32'h0000_2000, 0, 0, 0, 0, -1, 32'h0000_201C, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
